// File: rtl/sram_frame_sequencer.sv
// Frame-synchronous SRAM pixel recorder/player: one byte per pixel slot, written or read with
// fixed-length strobe sequences; the address restarts on every vsync rising edge.
module sram_frame_sequencer #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec,
  input  logic [1:0]        div_sel,
  input  logic              vsync,
  input  logic              pix_in,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] io_out,
  output logic              io_oe,
  input  logic [DATA_W-1:0] io_in,
  output logic              cs_n,
  output logic              we_n,
  output logic              oe_n,
  output logic              pix_out,
  output logic              pix_valid,
  output logic              frame_start,
  output logic              overflow
);

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWPulse,
    StWHold,
    StRAddr,
    StRSample
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          div_q, div_d;
  logic                mode_q, mode_d;
  logic                overflow_q, overflow_d;
  logic                pix_q, pix_d;
  logic                vsync_q, vsync_qq;
  logic                cs_n_q;

  logic [4:0]          slot_mask;
  logic                strobe;
  logic                start;
  logic                complete;
  logic                rd_hit;

  // Periods are powers of two dividing 32, so a 5-bit counter wraps cleanly for all of them.
  always_comb begin
    unique case (div_q)
      2'd0:    slot_mask = 5'd3;
      2'd1:    slot_mask = 5'd7;
      2'd2:    slot_mask = 5'd15;
      default: slot_mask = 5'd31;
    endcase
  end

  assign frame_start = vsync_q & ~vsync_qq;
  assign strobe      = (cnt_q & slot_mask) == 5'd0;
  assign start       = strobe & ~vsync_q & ~overflow_q;
  assign rd_hit      = &io_in;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q + 5'd1;
    div_d      = div_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;
    pix_d      = pix_q;
    complete   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wdata_d = {DATA_W{pix_in}};
          state_d = mode_q ? StWSetup : StRAddr;
        end
      end
      StWSetup:  state_d = StWPulse;
      StWPulse:  state_d = StWHold;
      StWHold: begin
        complete = 1'b1;
        state_d  = StIdle;
      end
      StRAddr:   state_d = StRSample;
      StRSample: begin
        pix_d    = rd_hit;
        complete = 1'b1;
        state_d  = StIdle;
      end
      default:   state_d = StIdle;
    endcase

    // The last address is written once, then the frame stalls until the next vsync.
    if (complete) begin
      if (addr_q == '1) begin
        overflow_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    if (frame_start) begin
      addr_d     = '0;
      overflow_d = 1'b0;
      cnt_d      = 5'd0;
      div_d      = div_sel;
      mode_d     = rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 5'd0;
      div_q      <= 2'd0;
      mode_q     <= 1'b0;
      overflow_q <= 1'b0;
      pix_q      <= 1'b0;
      vsync_q    <= 1'b0;
      vsync_qq   <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
      pix_q      <= pix_d;
      vsync_q    <= vsync;
      vsync_qq   <= vsync_q;
      cs_n_q     <= 1'b0;
    end
  end

  // Strobes decode straight from state so a reset edge drops them together with the FSM.
  assign io_oe     = (state_q == StWSetup) || (state_q == StWPulse) || (state_q == StWHold);
  assign we_n      = (state_q != StWPulse);
  assign oe_n      = !((state_q == StRAddr) || (state_q == StRSample));
  assign pix_valid = (state_q == StRSample);
  assign pix_out   = pix_valid ? rd_hit : pix_q;
  assign io_out    = wdata_q;
  assign addr      = addr_q;
  assign cs_n      = cs_n_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sram_frame_sequencer.sv
// Directed bench for sram_frame_sequencer built with a 4-bit address so overflow is reachable;
// the SRAM read model returns FF at even addresses and 00 at odd ones.
module tb_sram_frame_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          rec;
  logic [1:0]    div_sel;
  logic          vsync;
  logic          pix_in;
  logic [AW-1:0] addr;
  logic [DW-1:0] io_out;
  logic          io_oe;
  logic [DW-1:0] io_in;
  logic          cs_n;
  logic          we_n;
  logic          oe_n;
  logic          pix_out;
  logic          pix_valid;
  logic          frame_start;
  logic          overflow;

  int n_assert = 0;
  int n_fail   = 0;

  sram_frame_sequencer #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rec        (rec),
    .div_sel    (div_sel),
    .vsync      (vsync),
    .pix_in     (pix_in),
    .addr       (addr),
    .io_out     (io_out),
    .io_oe      (io_oe),
    .io_in      (io_in),
    .cs_n       (cs_n),
    .we_n       (we_n),
    .oe_n       (oe_n),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .overflow   (overflow)
  );

  assign io_in = addr[0] ? 8'h00 : 8'hFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus contention guard: the pad must never drive while the SRAM output is enabled.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_assert++;
      if (io_oe && !oe_n) begin
        n_fail++;
        $display("FAIL bus_contention: io_oe=%b oe_n=%b, required not both active", io_oe, oe_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise vsync for one cycle; caller must be one cycle before a slot strobe.
  task automatic frame(input logic rec_v, input logic [1:0] div_v, input logic [AW-1:0] exp_addr,
                       input logic exp_ovf);
    rec = rec_v;
    div_sel = div_v;
    vsync = 1'b1;
    tick();
    n_assert++;
    if ({frame_start, overflow, addr} !== {1'b1, exp_ovf, exp_addr}) begin
      n_fail++;
      $display("FAIL frame_start_pulse: fs/ovf/addr=%b/%b/%0d required 1/%b/%0d",
               frame_start, overflow, addr, exp_ovf, exp_addr);
    end
    vsync = 1'b0;
    tick();
    n_assert++;
    if ({frame_start, overflow, addr} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL frame_restart: fs/ovf/addr=%b/%b/%0d required 0/0/0",
               frame_start, overflow, addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rec = 1'b0; div_sel = 2'd0; vsync = 1'b0; pix_in = 1'b0;
    tick();
    tick();
    n_assert++;
    if ({addr, io_out, io_oe, we_n, oe_n, cs_n, pix_out, pix_valid, frame_start, overflow} !==
        {4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: addr=%0d io_out=%h oe/we_n/oe_n/cs_n=%b%b%b%b pix=%b pv=%b fs=%b ovf=%b required 0 00 0111 0 0 0 0",
               addr, io_out, io_oe, we_n, oe_n, cs_n, pix_out, pix_valid, frame_start, overflow);
    end
    // After reset the latched mode is playback, so the first slot issues a read.
    rst = 1'b0;
    tick();
    n_assert++;
    if ({cs_n, oe_n, io_oe, pix_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_read_addr: cs_n/oe_n/io_oe/pv=%b%b%b%b required 0000",
               cs_n, oe_n, io_oe, pix_valid);
    end
    tick();
    n_assert++;
    if ({pix_valid, pix_out, oe_n} !== 3'b110) begin
      n_fail++;
      $display("FAIL post_reset_read_sample: pv/pix/oe_n=%b%b%b required 110",
               pix_valid, pix_out, oe_n);
    end
    tick();
    n_assert++;
    if ({pix_valid, oe_n, addr} !== {1'b0, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL post_reset_read_done: pv=%b oe_n=%b addr=%0d required 0 1 1",
               pix_valid, oe_n, addr);
    end
  endtask

  task automatic test_record();
    logic [7:0] exp_d;
    frame(1'b1, 2'd0, 4'd1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      exp_d  = n[0] ? 8'h00 : 8'hFF;
      pix_in = ~n[0];
      tick();
      n_assert++;
      if ({io_oe, we_n, oe_n, io_out, addr} !== {1'b1, 1'b1, 1'b1, exp_d, 4'(n)}) begin
        n_fail++;
        $display("FAIL rec_setup[%0d]: oe/we_n/oe_n=%b%b%b data=%h addr=%0d required 111 %h %0d",
                 n, io_oe, we_n, oe_n, io_out, addr, exp_d, n);
      end
      tick();
      n_assert++;
      if ({io_oe, we_n, io_out} !== {1'b1, 1'b0, exp_d}) begin
        n_fail++;
        $display("FAIL rec_pulse[%0d]: io_oe/we_n=%b%b data=%h required 10 %h",
                 n, io_oe, we_n, io_out, exp_d);
      end
      tick();
      n_assert++;
      if ({io_oe, we_n} !== 2'b11) begin
        n_fail++;
        $display("FAIL rec_hold[%0d]: io_oe/we_n=%b%b required 11", n, io_oe, we_n);
      end
      if (n < 7) begin
        tick();
        n_assert++;
        if ({io_oe, we_n, addr} !== {1'b0, 1'b1, 4'(n + 1)}) begin
          n_fail++;
          $display("FAIL rec_idle[%0d]: io_oe/we_n=%b%b addr=%0d required 01 %0d",
                   n, io_oe, we_n, addr, n + 1);
        end
      end
    end
  endtask

  task automatic test_playback();
    logic exp_p;
    frame(1'b0, 2'd0, 4'd8, 1'b0);
    for (int n = 0; n < 4; n++) begin
      exp_p = (n % 2 == 0);
      tick();
      n_assert++;
      if ({oe_n, io_oe, pix_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL play_addr[%0d]: oe_n/io_oe/pv=%b%b%b required 000",
                 n, oe_n, io_oe, pix_valid);
      end
      tick();
      n_assert++;
      if ({pix_valid, pix_out, oe_n, io_oe} !== {1'b1, exp_p, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL play_sample[%0d]: pv/pix/oe_n/io_oe=%b%b%b%b required 1%b00",
                 n, pix_valid, pix_out, oe_n, io_oe, exp_p);
      end
      tick();
      n_assert++;
      if ({pix_valid, pix_out, oe_n, addr} !== {1'b0, exp_p, 1'b1, 4'(n + 1)}) begin
        n_fail++;
        $display("FAIL play_done[%0d]: pv/pix/oe_n=%b%b%b addr=%0d required 0%b1 %0d",
                 n, pix_valid, pix_out, oe_n, addr, exp_p, n + 1);
      end
      if (n < 3) tick();
    end
  endtask

  task automatic test_div_sel();
    logic exp_v;
    frame(1'b0, 2'd0, 4'd4, 1'b0);
    div_sel = 2'd3;
    for (int c = 1; c < 12; c++) begin
      tick();
      exp_v = (c % 4 == 2);
      n_assert++;
      if (pix_valid !== exp_v) begin
        n_fail++;
        $display("FAIL div_midframe c=%0d: pix_valid=%b required %b", c, pix_valid, exp_v);
      end
    end
    frame(1'b0, 2'd3, 4'd3, 1'b0);
    for (int c = 1; c < 64; c++) begin
      tick();
      exp_v = (c % 32 == 2);
      n_assert++;
      if (pix_valid !== exp_v) begin
        n_fail++;
        $display("FAIL div_period32 c=%0d: pix_valid=%b required %b", c, pix_valid, exp_v);
      end
    end
  endtask

  task automatic test_mode_latch();
    logic exp_oe_n;
    frame(1'b0, 2'd0, 4'd2, 1'b0);
    rec = 1'b1;
    for (int c = 1; c < 8; c++) begin
      tick();
      exp_oe_n = !((c % 4 == 1) || (c % 4 == 2));
      n_assert++;
      if ({we_n, io_oe, oe_n} !== {1'b1, 1'b0, exp_oe_n}) begin
        n_fail++;
        $display("FAIL mode_midframe c=%0d: we_n/io_oe/oe_n=%b%b%b required 10%b",
                 c, we_n, io_oe, oe_n, exp_oe_n);
      end
    end
    frame(1'b1, 2'd0, 4'd2, 1'b0);
    pix_in = 1'b1;
    tick();
    n_assert++;
    if ({io_oe, oe_n, io_out} !== {1'b1, 1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL mode_new_frame: io_oe/oe_n=%b%b data=%h required 11 ff", io_oe, oe_n, io_out);
    end
    tick();
    n_assert++;
    if (we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_new_write: we_n=%b required 0", we_n);
    end
    tick();
  endtask

  task automatic test_overflow();
    int we_lows;
    int extra;
    we_lows = 0;
    extra   = 0;
    frame(1'b1, 2'd0, 4'd1, 1'b0);
    pix_in = 1'b1;
    for (int c = 1; c < 64; c++) begin
      tick();
      if (we_n === 1'b0) we_lows++;
    end
    n_assert++;
    if (we_lows != 16) begin
      n_fail++;
      $display("FAIL ovf_write_count: we_n pulses=%0d required 16", we_lows);
    end
    n_assert++;
    if ({overflow, addr} !== {1'b0, 4'd15}) begin
      n_fail++;
      $display("FAIL ovf_last_access: ovf=%b addr=%0d required 0 15", overflow, addr);
    end
    tick();
    n_assert++;
    if ({overflow, addr, io_oe} !== {1'b1, 4'd15, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b addr=%0d io_oe=%b required 1 15 0", overflow, addr, io_oe);
    end
    for (int c = 65; c < 76; c++) begin
      tick();
      if (we_n !== 1'b1 || io_oe !== 1'b0) extra++;
    end
    n_assert++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ovf_suppress: active cycles=%0d required 0", extra);
    end
    frame(1'b1, 2'd0, 4'd15, 1'b1);
    tick();
    n_assert++;
    if ({io_oe, addr} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL ovf_resume: io_oe=%b addr=%0d required 1 0", io_oe, addr);
    end
    tick();
    n_assert++;
    if (we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_resume_pulse: we_n=%b required 0", we_n);
    end
  endtask

  // Entered in W_PULSE: vsync lands so frame_start coincides with W_HOLD.
  task automatic test_frame_collision();
    vsync = 1'b1;
    tick();
    n_assert++;
    if ({frame_start, we_n, io_oe} !== 3'b111) begin
      n_fail++;
      $display("FAIL collide_hold: fs/we_n/io_oe=%b%b%b required 111", frame_start, we_n, io_oe);
    end
    vsync = 1'b0;
    tick();
    n_assert++;
    if ({frame_start, addr, io_oe, overflow} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL collide_addr: fs=%b addr=%0d io_oe=%b ovf=%b required 0 0 0 0",
               frame_start, addr, io_oe, overflow);
    end
  endtask

  task automatic test_reset_mid();
    pix_in = 1'b0;
    for (int c = 1; c < 11; c++) tick();
    n_assert++;
    if ({we_n, io_oe, addr, io_out} !== {1'b0, 1'b1, 4'd2, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_pre: we_n/io_oe=%b%b addr=%0d data=%h required 01 2 00",
               we_n, io_oe, addr, io_out);
    end
    rst = 1'b1;
    tick();
    n_assert++;
    if ({we_n, io_oe, oe_n, cs_n, addr, io_out, pix_valid} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_abort: we_n/io_oe/oe_n/cs_n=%b%b%b%b addr=%0d data=%h pv=%b required 1011 0 00 0",
               we_n, io_oe, oe_n, cs_n, addr, io_out, pix_valid);
    end
    tick();
    n_assert++;
    if ({we_n, io_oe} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_held: we_n/io_oe=%b%b required 10", we_n, io_oe);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_record();
    test_playback();
    test_div_sel();
    test_mode_latch();
    test_overflow();
    test_frame_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
